// File: rtl/ccl_frame_sequencer_if.sv
// Connects the frame sequencer to its neighbours: the upstream pixel
// handshake, the labeler control/coordinates and the merge-table port.
// The sequencer is the master, the labeler/stream side is the slave.
interface ccl_frame_sequencer_if #(
  parameter int LABEL_W = 8
);
  // Upstream pixel stream
  logic               pix_valid;
  logic               pix_ready;

  // Labeler control and coordinates
  logic               ccl_en;
  logic               ccl_force_bg;
  logic [31:0]        ccl_x;
  logic [31:0]        ccl_y;
  logic               stack_empty_0;
  logic               stack_empty_1;
  logic [LABEL_W-1:0] num_labels;

  // Merge-table port
  logic [LABEL_W-1:0] tbl_addr;
  logic               tbl_rd_en;
  logic [LABEL_W-1:0] tbl_rd_data;
  logic               tbl_wr_en;
  logic [LABEL_W-1:0] tbl_wr_data;

  modport master (
    input  pix_valid, stack_empty_0, stack_empty_1, num_labels, tbl_rd_data,
    output pix_ready, ccl_en, ccl_force_bg, ccl_x, ccl_y,
           tbl_addr, tbl_rd_en, tbl_wr_en, tbl_wr_data
  );

  modport slave (
    output pix_valid, stack_empty_0, stack_empty_1, num_labels, tbl_rd_data,
    input  pix_ready, ccl_en, ccl_force_bg, ccl_x, ccl_y,
           tbl_addr, tbl_rd_en, tbl_wr_en, tbl_wr_data
  );
endinterface

// File: rtl/ccl_frame_sequencer.sv
// Frame-level controller for the connected-components labeler.
// Streams one raster frame into the labeler, drains both merge stacks with
// background pixels, then flattens the merge table in a single ascending
// pass (roots always carry lower labels than their children) and pulses done.
module ccl_frame_sequencer #(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int LABEL_W   = 8,
  parameter int DRAIN_MAX = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err_drain,
  ccl_frame_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_FL_RD_I,
    S_FL_RD_P,
    S_FL_WR,
    S_DONE
  } state_t;

  localparam logic [31:0] X_LAST   = 32'(IMG_W - 1);
  localparam logic [31:0] Y_LAST   = 32'(IMG_H - 1);
  localparam logic [31:0] Y_DRAIN0 = 32'(IMG_H);
  localparam logic [31:0] Y_DRAIN1 = 32'(IMG_H + 1);
  localparam int          CNT_W    = $clog2(DRAIN_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_MAX - 1);

  state_t             state, state_next;
  logic [31:0]        x, y;
  logic [CNT_W-1:0]   drain_cnt;
  logic [LABEL_W-1:0] i;       // entry being flattened
  logic [LABEL_W-1:0] i_last;  // num_labels-1, captured at drain exit

  logic stacks_empty;
  logic drain_timeout;
  logic drain_exit;
  logic last_pixel;
  logic flatten_go;
  logic last_entry;

  assign stacks_empty  = bus.stack_empty_0 & bus.stack_empty_1;
  assign drain_timeout = (drain_cnt == CNT_LAST);
  assign drain_exit    = stacks_empty | drain_timeout;
  assign last_pixel    = (x == X_LAST) && (y == Y_LAST);
  // num_labels == 0 is the overflow case: 2^LABEL_W labels, flatten all.
  assign flatten_go    = (bus.num_labels == '0) || (bus.num_labels > LABEL_W'(2));
  assign last_entry    = (i == i_last);

  assign bus.ccl_x = x;
  assign bus.ccl_y = y;

  // State register; reset drops straight back to IDLE from any state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      // NOTE: sequential state is always assigned with <= so every register
      // samples the pre-edge values of its neighbours.
      state <= state_next;
    end
  end

  // Next-state and Moore/Mealy outputs for the frame sequence.
  always_comb begin
    // NOTE: every output gets a default before the case so no path through
    // the block leaves a signal unassigned (which would infer a latch).
    state_next       = state;
    busy             = (state != S_IDLE);
    done             = 1'b0;
    bus.pix_ready    = 1'b0;
    bus.ccl_en       = 1'b0;
    bus.ccl_force_bg = 1'b0;
    bus.tbl_addr     = '0;
    bus.tbl_rd_en    = 1'b0;
    bus.tbl_wr_en    = 1'b0;
    bus.tbl_wr_data  = '0;

    case (state)
      S_IDLE: begin
        if (start) state_next = S_SCAN;
      end
      S_SCAN: begin
        bus.pix_ready = 1'b1;
        bus.ccl_en    = bus.pix_valid;
        if (bus.pix_valid && last_pixel) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        bus.ccl_en       = 1'b1;
        bus.ccl_force_bg = 1'b1;
        if (drain_exit) state_next = flatten_go ? S_FL_RD_I : S_DONE;
      end
      S_FL_RD_I: begin
        bus.tbl_addr  = i;
        bus.tbl_rd_en = 1'b1;
        state_next    = S_FL_RD_P;
      end
      S_FL_RD_P: begin
        // Read data is the parent p of entry i; fetch table[p] directly.
        bus.tbl_addr  = bus.tbl_rd_data;
        bus.tbl_rd_en = 1'b1;
        state_next    = S_FL_WR;
      end
      S_FL_WR: begin
        // table[p] is already a root because p < i was flattened earlier.
        bus.tbl_addr    = i;
        bus.tbl_wr_en   = 1'b1;
        bus.tbl_wr_data = bus.tbl_rd_data;
        state_next      = last_entry ? S_DONE : S_FL_RD_I;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Coordinates, drain counter, flatten index and the sticky drain error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x         <= '0;
      y         <= '0;
      drain_cnt <= '0;
      i         <= '0;
      i_last    <= '0;
      err_drain <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            x         <= '0;
            y         <= '0;
            drain_cnt <= '0;
            i         <= LABEL_W'(1);
            err_drain <= 1'b0;
          end
        end
        S_SCAN: begin
          if (bus.pix_valid) begin
            if (x == X_LAST) begin
              // Wrapping past the last row lands y on IMG_H, the first drain row.
              x <= '0;
              y <= y + 32'd1;
            end else begin
              x <= x + 32'd1;
            end
          end
        end
        S_DRAIN: begin
          // Alternate rows so each merge stack sees its pop parity.
          y         <= (y == Y_DRAIN0) ? Y_DRAIN1 : Y_DRAIN0;
          drain_cnt <= drain_cnt + CNT_W'(1);
          if (drain_exit) begin
            i_last <= bus.num_labels - LABEL_W'(1);
            if (!stacks_empty) err_drain <= 1'b1;
          end
        end
        S_FL_WR: begin
          if (!last_entry) i <= i + LABEL_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ccl_frame_sequencer.sv
// Bench for ccl_frame_sequencer on a 4x2 frame. A timeline model derived
// from the frame/drain/flatten rules predicts every cycle's outputs, and the
// merge table is modelled as a 256-entry memory with one-cycle read latency.
// Expected flatten results come from chasing parent pointers to the root.
module tb_ccl_frame_sequencer;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int LW    = 8;
  localparam int DMAX  = 32;
  localparam int FRAME = W * H;

  logic clk;
  logic reset;
  logic start;
  logic busy;
  logic done;
  logic err_drain;

  ccl_frame_sequencer_if #(.LABEL_W(LW)) bus ();

  ccl_frame_sequencer #(
    .IMG_W    (W),
    .IMG_H    (H),
    .LABEL_W  (LW),
    .DRAIN_MAX(DMAX)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .err_drain(err_drain),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Merge-table memory and its pre-frame contents.
  logic [7:0] mem  [256];
  logic [7:0] orig [256];
  logic       load_en;
  logic [7:0] load_addr;
  logic [7:0] load_data;

  int n_checks = 0;
  int n_fail   = 0;

  always @(posedge clk) begin
    if (load_en)            mem[load_addr]    <= load_data;
    else if (bus.tbl_wr_en) mem[bus.tbl_addr] <= bus.tbl_wr_data;
    if (bus.tbl_rd_en)      bus.tbl_rd_data   <= mem[bus.tbl_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ctl_vec();
    return {busy, done, bus.pix_ready, bus.ccl_en, bus.ccl_force_bg,
            bus.tbl_rd_en, bus.tbl_wr_en, err_drain};
  endfunction

  // Root of label j in the original table (parents never exceed children).
  function automatic int root(input int j);
    int r = j;
    for (int s = 0; s < 256; s++) begin
      if (int'(orig[8'(r)]) == r) break;
      r = int'(orig[8'(r)]);
    end
    return r;
  endfunction

  // rnd=0: {1:1, 2:1, 3:2, 4:3}, identity elsewhere; rnd=1: random forest.
  task automatic load_table(input bit rnd);
    for (int j = 0; j < 256; j++) begin
      @(negedge clk);
      load_en   = 1'b1;
      load_addr = 8'(j);
      if (j == 0)   load_data = 8'd0;
      else if (rnd) load_data = 8'($urandom_range(1, j));
      else if (j == 2) load_data = 8'd1;
      else if (j == 3) load_data = 8'd2;
      else if (j == 4) load_data = 8'd3;
      else             load_data = 8'(j);
      orig[j] = load_data;
    end
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // mode: 0 valid always, 1 valid toggles 1,0,1,0..., 2 random valid.
  // hold1: drain cycles with stack 1 non-empty; stuck0: stack 0 never empties.
  // reset_at: flatten cycle index at which reset is asserted (-1 = never).
  task automatic run_frame(input bit rnd_tbl, input int mode, input int hold1,
                           input bit stuck0, input logic [7:0] nl, input int reset_at);
    int  n, flat_len, drain_len, n_tr, d, f, idx, sub;
    bit  exp_err, pv, flat_on, finished;
    n         = (nl == 8'd0) ? 256 : int'(nl);
    flat_on   = (n > 2);
    flat_len  = flat_on ? 3 * (n - 1) : 0;
    exp_err   = stuck0 || (hold1 >= DMAX);
    drain_len = exp_err ? DMAX : hold1 + 1;
    n_tr = 0; d = 0; f = 0;
    finished = 1'b0;

    load_table(rnd_tbl);
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k < 2000; k++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      pv    = 1'($urandom_range(0, 1));
      if (mode == 0) pv = 1'b1;
      if (mode == 1) pv = ((k - 1) % 2 == 0);
      bus.pix_valid = pv;
      if (n_tr >= FRAME && d < drain_len) begin
        bus.stack_empty_0 = !stuck0;
        bus.stack_empty_1 = (d >= hold1);
        bus.num_labels    = nl;
      end else begin
        bus.stack_empty_0 = 1'($urandom_range(0, 1));
        bus.stack_empty_1 = 1'($urandom_range(0, 1));
        bus.num_labels    = 8'($urandom);
      end
      #1;
      if (n_tr < FRAME) begin
        check("ctl_scan", 32'(ctl_vec()), 32'({1'b1, 1'b0, 1'b1, pv, 4'b0000}));
        check("scan_x", bus.ccl_x, n_tr % W);
        check("scan_y", bus.ccl_y, n_tr / W);
        if (pv) n_tr++;
      end else if (d < drain_len) begin
        check("ctl_drain", 32'(ctl_vec()), 32'(8'b1001_1000));
        check("drain_x", bus.ccl_x, 0);
        check("drain_y", bus.ccl_y, H + (d % 2));
        d++;
      end else if (f < flat_len) begin
        idx = 1 + f / 3;
        sub = f % 3;
        if (f == reset_at) begin
          reset = 1'b1;
          #1;
          check("rst_ctl", 32'(ctl_vec()), 0);
          check("rst_x", bus.ccl_x, 0);
          check("rst_y", bus.ccl_y, 0);
          check("rst_addr", 32'(bus.tbl_addr), 0);
          check("rst_wdata", 32'(bus.tbl_wr_data), 0);
          @(negedge clk);
          reset = 1'b0;
          start = 1'b0;
          return;
        end
        check("ctl_flat", 32'(ctl_vec()),
              32'({5'b10000, (sub != 2), (sub == 2), exp_err}));
        check("flat_addr", 32'(bus.tbl_addr), (sub == 1) ? 32'(orig[8'(idx)]) : idx);
        if (sub == 2) check("flat_wdata", 32'(bus.tbl_wr_data), root(idx));
        f++;
      end else begin
        check("ctl_done", 32'(ctl_vec()), 32'({7'b1100000, exp_err}));
        finished = 1'b1;
        break;
      end
    end
    check("frame_end", 32'(finished), 1);

    @(negedge clk);
    start = 1'b0;
    #1;
    check("ctl_idle", 32'(ctl_vec()), 32'({7'b0000000, exp_err}));
    for (int j = 0; j < 256; j++) begin
      check("table", 32'(mem[j]),
            (flat_on && j >= 1 && j < n) ? root(j) : 32'(orig[j]));
    end
  endtask

  initial begin
    reset             = 1'b1;
    start             = 1'b0;
    load_en           = 1'b0;
    load_addr         = 8'd0;
    load_data         = 8'd0;
    bus.pix_valid     = 1'b0;
    bus.stack_empty_0 = 1'b1;
    bus.stack_empty_1 = 1'b1;
    bus.num_labels    = 8'd0;

    repeat (2) @(negedge clk);
    #1;
    check("reset_ctl", 32'(ctl_vec()), 0);
    check("reset_x", bus.ccl_x, 0);
    check("reset_y", bus.ccl_y, 0);
    check("reset_addr", 32'(bus.tbl_addr), 0);
    check("reset_wdata", 32'(bus.tbl_wr_data), 0);
    @(negedge clk);
    reset = 1'b0;

    // Background frame: 8 transfers, 1 drain cycle, no flatten, done at cycle 10.
    run_frame(1'b0, 0, 0, 1'b0, 8'd1, -1);
    // Backpressure, stack 1 busy for 3 drain cycles, fixed table flatten.
    run_frame(1'b0, 1, 3, 1'b0, 8'd5, -1);
    // Stack 0 stuck: drain timeout sets err_drain, flatten skipped.
    run_frame(1'b1, 0, 0, 1'b1, 8'd2, -1);
    // Next start clears err_drain.
    run_frame(1'b0, 0, 0, 1'b0, 8'd5, -1);
    for (int r = 0; r < 3; r++) begin
      run_frame(1'b1, 2, int'($urandom_range(0, 6)), 1'b0, 8'($urandom_range(1, 12)), -1);
    end
    // Reset during FL_RD_P of entry 2, then a clean frame.
    run_frame(1'b0, 0, 1, 1'b0, 8'd5, 4);
    run_frame(1'b1, 2, 0, 1'b0, 8'd5, -1);
    // Label overflow: full 255-entry flatten.
    run_frame(1'b1, 0, 0, 1'b0, 8'd0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
